// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed load/store memory target with programmable wait states
module data_mem_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [15:0]       st_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [15:0]         st_q, st_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                acc_fire, acc_we, acc_oor, mem_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic [IDX_W-1:0]    acc_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req) begin
                if (LATENCY == 0) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    cnt_d   = LAT_M1;
                end
            end
            WAIT: if (cnt_q == 4'd0) state_d = RESP;
                  else               cnt_d   = cnt_q - 4'd1;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The access happens on the edge entering RESP so ack/rdata are registered;
    // with zero latency that edge is the accepting edge, so the live fields are used.
    always_comb begin
        acc_fire  = (state_q == IDLE && req && LATENCY == 0) ||
                    (state_q == WAIT && cnt_q == 4'd0);
        acc_we    = (state_q == IDLE) ? we    : we_q;
        acc_addr  = (state_q == IDLE) ? addr  : addr_q;
        acc_wdata = (state_q == IDLE) ? wdata : wdata_q;
        acc_oor   = acc_addr >= DEPTH_A;
        acc_idx   = acc_addr[IDX_W-1:0];
        mem_we    = acc_fire && acc_we && !acc_oor;

        we_d    = (state_q == IDLE && req) ? we    : we_q;
        addr_d  = (state_q == IDLE && req) ? addr  : addr_q;
        wdata_d = (state_q == IDLE && req) ? wdata : wdata_q;
        ack_d   = acc_fire;
        err_d   = acc_fire ? acc_oor : err_q;

        rdata_d = rdata_q;
        if (acc_fire) begin
            if (acc_oor)      rdata_d = '0;
            else if (!acc_we) rdata_d = mem_q[acc_idx];
        end

        st_d = st_q;
        if (mem_we && st_q != 16'hFFFF) st_d = st_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            st_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            st_q    <= st_d;
            if (mem_we) mem_q[acc_idx] <= acc_wdata;
        end
    end

    always_comb begin
        busy     = (state_q != IDLE);
        ack      = ack_q;
        err      = err_q;
        rdata    = rdata_q;
        st_count = st_q;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed bench for data_mem_responder at LATENCY 2 and 0
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        req0 = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] wdata = '0;

    logic        busy, ack, err, busy0, ack0, err0;
    logic [31:0] rdata, rdata0;
    logic [15:0] st_count, st_count0;

    int vec = 0;
    int miscmp = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DATA_W(32), .ADDR_W(16), .DEPTH(64), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy), .ack(ack), .rdata(rdata), .err(err), .st_count(st_count)
    );

    data_mem_responder #(.DATA_W(32), .ADDR_W(16), .DEPTH(64), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy0), .ack(ack0), .rdata(rdata0), .err(err0), .st_count(st_count0)
    );

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        req = 1'b0;
        req0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // Issues one request, holds it until ack, returns cycles from acceptance to ack
    // and the number of busy cycles; ends in the idle cycle after ack.
    task automatic txn(input bit sel, input logic w, input logic [15:0] a, input logic [31:0] d,
                       output int lat, output int bcnt, output logic e, output logic [31:0] rd);
        bit got;
        lat = 0; bcnt = 0; got = 0; e = 1'b0; rd = '0;
        we = w; addr = a; wdata = d;
        if (sel) req0 = 1'b1; else req = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (sel ? busy0 : busy) bcnt++;
            if (sel ? ack0 : ack) begin
                got = 1;
                e  = sel ? err0 : err;
                rd = sel ? rdata0 : rdata;
                req = 1'b0; req0 = 1'b0;
            end
        end
        if (!got) begin
            vec++; miscmp++;
            $display("FAIL ack_timeout: no ack within 20 cycles (sel=%0d addr=%h)", sel, a);
            req = 1'b0; req0 = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        vec++; if (busy !== 1'b0)      begin miscmp++; $display("FAIL reset_busy: got %b want 0", busy); end
        vec++; if (ack !== 1'b0)       begin miscmp++; $display("FAIL reset_ack: got %b want 0", ack); end
        vec++; if (rdata !== 32'h0)    begin miscmp++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        vec++; if (err !== 1'b0)       begin miscmp++; $display("FAIL reset_err: got %b want 0", err); end
        vec++; if (st_count !== 16'h0) begin miscmp++; $display("FAIL reset_st_count: got %h want 0", st_count); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        int lat, bc; logic e; logic [31:0] rd;
        txn(0, 1'b1, 16'd1, 32'h2, lat, bc, e, rd);
        vec++; if (lat != 3)   begin miscmp++; $display("FAIL store_latency: got %0d want 3", lat); end
        vec++; if (bc != 3)    begin miscmp++; $display("FAIL store_busy_cycles: got %0d want 3", bc); end
        vec++; if (e !== 1'b0) begin miscmp++; $display("FAIL store_err: got %b want 0", e); end
        vec++; if (st_count !== 16'd1) begin miscmp++; $display("FAIL store_st_count: got %0d want 1", st_count); end
    endtask

    task automatic test_load();
        int lat, bc; logic e; logic [31:0] rd;
        txn(0, 1'b0, 16'd1, 32'h0, lat, bc, e, rd);
        vec++; if (lat != 3)       begin miscmp++; $display("FAIL load_latency: got %0d want 3", lat); end
        vec++; if (rd !== 32'h2)   begin miscmp++; $display("FAIL load_after_store: got %h want 2", rd); end
        txn(0, 1'b0, 16'd5, 32'h0, lat, bc, e, rd);
        vec++; if (rd !== 32'h0)   begin miscmp++; $display("FAIL load_unwritten: got %h want 0", rd); end
        vec++; if (st_count !== 16'd1) begin miscmp++; $display("FAIL load_st_count: got %0d want 1", st_count); end
    endtask

    task automatic test_out_of_range();
        int lat, bc; logic e; logic [31:0] rd;
        txn(0, 1'b1, 16'h0040, 32'hDEAD_BEEF, lat, bc, e, rd);
        vec++; if (e !== 1'b1)  begin miscmp++; $display("FAIL oor_err: got %b want 1", e); end
        vec++; if (st_count !== 16'd1) begin miscmp++; $display("FAIL oor_st_count: got %0d want 1", st_count); end
        txn(0, 1'b0, 16'h0000, 32'h0, lat, bc, e, rd);
        vec++; if (rd !== 32'h0) begin miscmp++; $display("FAIL oor_no_alias: got %h want 0", rd); end
        vec++; if (e !== 1'b0)   begin miscmp++; $display("FAIL oor_err_clear: got %b want 0", e); end
        txn(0, 1'b0, 16'h8001, 32'h0, lat, bc, e, rd);
        vec++; if (e !== 1'b1 || rd !== 32'h0) begin
            miscmp++; $display("FAIL oor_high_bits: got err=%b rdata=%h want err=1 rdata=0", e, rd);
        end
    endtask

    task automatic test_back_to_back();
        int n_ack, last, min_gap, lat, bc; logic e; logic [31:0] rd;
        do_reset();
        n_ack = 0; last = -10; min_gap = 1000;
        we = 1'b1; addr = 16'd0; wdata = 32'd100; req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (ack) begin
                n_ack++;
                if (c - last < min_gap) min_gap = c - last;
                last = c;
                addr = addr + 16'd1; wdata = wdata + 32'd1;
                if (n_ack == 3) req = 1'b0;
            end
        end
        vec++; if (n_ack != 3)    begin miscmp++; $display("FAIL b2b_ack_count: got %0d want 3", n_ack); end
        vec++; if (min_gap != 4)  begin miscmp++; $display("FAIL b2b_ack_spacing: got %0d want 4", min_gap); end
        vec++; if (st_count !== 16'd3) begin miscmp++; $display("FAIL b2b_st_count: got %0d want 3", st_count); end
        txn(0, 1'b0, 16'd2, 32'h0, lat, bc, e, rd);
        vec++; if (rd !== 32'd102) begin miscmp++; $display("FAIL b2b_data: got %0d want 102", rd); end

        n_ack = 0;
        we = 1'b0; addr = 16'd0; req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (ack) n_ack++;
            req = (c == 2);
        end
        vec++; if (n_ack != 1) begin miscmp++; $display("FAIL toggle_while_busy: got %0d acks want 1", n_ack); end
    endtask

    task automatic test_zero_latency();
        int lat, bc; logic e; logic [31:0] rd;
        txn(1, 1'b1, 16'h10, 32'hABCD, lat, bc, e, rd);
        vec++; if (lat != 1) begin miscmp++; $display("FAIL zl_store_latency: got %0d want 1", lat); end
        txn(1, 1'b0, 16'h10, 32'h0, lat, bc, e, rd);
        vec++; if (lat != 1)         begin miscmp++; $display("FAIL zl_load_latency: got %0d want 1", lat); end
        vec++; if (bc != 1)          begin miscmp++; $display("FAIL zl_busy_cycles: got %0d want 1", bc); end
        vec++; if (rd !== 32'hABCD)  begin miscmp++; $display("FAIL zl_rdata: got %h want abcd", rd); end
        vec++; if (st_count0 !== 16'd1) begin miscmp++; $display("FAIL zl_st_count: got %0d want 1", st_count0); end
    endtask

    task automatic test_reset_abort();
        int lat, bc, n_ack; logic e; logic [31:0] rd;
        txn(0, 1'b1, 16'd3, 32'd9, lat, bc, e, rd);
        we = 1'b1; addr = 16'd3; wdata = 32'd7; req = 1'b1;
        @(posedge clk); #1;
        vec++; if (busy !== 1'b1) begin miscmp++; $display("FAIL abort_busy_before: got %b want 1", busy); end
        rst = 1'b0;
        #2;
        vec++; if (busy !== 1'b0)      begin miscmp++; $display("FAIL abort_busy: got %b want 0", busy); end
        vec++; if (ack !== 1'b0)       begin miscmp++; $display("FAIL abort_ack: got %b want 0", ack); end
        vec++; if (st_count !== 16'd0) begin miscmp++; $display("FAIL abort_st_count: got %0d want 0", st_count); end
        @(posedge clk); #1;
        req = 1'b0;
        rst = 1'b1;
        n_ack = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ack) n_ack++;
        end
        vec++; if (n_ack != 0) begin miscmp++; $display("FAIL abort_no_ack: got %0d acks want 0", n_ack); end
        txn(0, 1'b0, 16'd3, 32'h0, lat, bc, e, rd);
        vec++; if (rd !== 32'h0) begin miscmp++; $display("FAIL abort_mem_cleared: got %h want 0", rd); end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_out_of_range();
        test_back_to_back();
        test_zero_latency();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
